// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional watchdog abort on stalled frames when PS2_RX_TIMEOUT_EN is defined.
module ps2_frame_rx #(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int TIMEOUT_W      = 14
) (
    input  logic       clk,
    input  logic       i_sclr,
    input  logic       i_en,
    input  logic       i_dat,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_parity_err,
    output logic       o_frame_err,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state_q;
    logic [7:0] shreg_q;
    logic [3:0] cnt_q;
    logic       par_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       perr_q;
    logic       ferr_q;
    logic       timeout;

    if (TIMEOUT_W < $clog2(TIMEOUT_CYCLES)) begin : g_bad_timeout_w
        $error("TIMEOUT_W cannot hold TIMEOUT_CYCLES-1");
    end

`ifdef PS2_RX_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog_q;
    logic [TIMEOUT_W-1:0] wdog_d;

    always_comb begin
        wdog_d = wdog_q + 1'b1;
        if (state_q == IDLE || i_en) begin
            wdog_d = '0;
        end
    end

    // An edge in the expiry cycle wins: it is processed and the counter clears.
    assign timeout = (state_q != IDLE) && !i_en &&
                     (wdog_d == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (i_sclr || timeout) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (i_sclr) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            // NOTE: default the result strobes low with <= so later branches can raise them for one cycle.
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            if (timeout) begin
                state_q <= IDLE;
                ferr_q  <= 1'b1;
            end else if (i_en) begin
                case (state_q)
                    IDLE: begin
                        if (!i_dat) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                        end
                    end
                    DATA: begin
                        shreg_q <= {i_dat, shreg_q[7:1]};
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_q   <= i_dat;
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                        if (!i_dat) begin
                            ferr_q <= 1'b1;
                        end else if ((^shreg_q) ^ par_q) begin
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                        end else begin
                            perr_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_parity_err = perr_q;
    assign o_frame_err  = ferr_q;
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Self-checking bench for ps2_frame_rx: directed frames plus randomized frames against a frame-level model.
// Covers the watchdog path when PS2_RX_TIMEOUT_EN is defined.
module tb_ps2_frame_rx;

    localparam int T = 16;

    logic       clk = 1'b0;
    logic       i_sclr;
    logic       i_en;
    logic       i_dat;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_parity_err;
    logic       o_frame_err;
    logic       o_busy;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] model_data;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(T),
        .TIMEOUT_W     (14)
    ) dut (
        .clk         (clk),
        .i_sclr      (i_sclr),
        .i_en        (i_en),
        .i_dat       (i_dat),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_parity_err(o_parity_err),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_en  = 1'b0;
            i_dat = 1'($urandom);
            tick();
        end
    endtask

    task automatic edge_bit(input logic b);
        i_en  = 1'b1;
        i_dat = b;
        tick();
        i_en  = 1'b0;
        i_dat = 1'($urandom);
    endtask

    // Drives a whole frame; the outcome is derived from the frame's bits alone.
    task automatic send_frame(input string tag, input logic [7:0] d, input logic par,
                              input logic stop, input int gap);
        logic exp_v, exp_p, exp_f;
        edge_bit(1'b0);
        check({tag, "_busy_start"}, 32'(o_busy), 32'd1);
        idle(gap);
        for (int i = 0; i < 8; i++) begin
            edge_bit(d[i]);
            check({tag, "_quiet"}, {29'd0, o_valid, o_parity_err, o_frame_err}, 32'd0);
            idle(gap);
        end
        edge_bit(par);
        idle(gap);
        edge_bit(stop);
        exp_f = !stop;
        exp_v = stop && ((($countones(d) + int'(par)) % 2) == 1);
        exp_p = stop && !exp_v;
        if (exp_v) model_data = d;
        check({tag, "_valid"}, 32'(o_valid), 32'(exp_v));
        check({tag, "_perr"}, 32'(o_parity_err), 32'(exp_p));
        check({tag, "_ferr"}, 32'(o_frame_err), 32'(exp_f));
        check({tag, "_data"}, 32'(o_data), 32'(model_data));
        check({tag, "_busy_end"}, 32'(o_busy), 32'd0);
        idle(1);
        check({tag, "_one_cycle"}, {29'd0, o_valid, o_parity_err, o_frame_err}, 32'd0);
        check({tag, "_hold"}, 32'(o_data), 32'(model_data));
    endtask

    initial begin
        i_sclr = 1'b1;
        i_en   = 1'b0;
        i_dat  = 1'b1;
        model_data = 8'h00;
        tick();
        tick();
        i_sclr = 1'b0;
        check("rst_data", 32'(o_data), 32'h00);
        check("rst_pulses", {29'd0, o_valid, o_parity_err, o_frame_err}, 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        idle(2);

        send_frame("good_1c", 8'h1C, 1'b0, 1'b1, 2);
        idle(1);
        send_frame("perr_1c", 8'h1C, 1'b1, 1'b1, 2);
        idle(1);
        send_frame("ferr_1c", 8'h1C, 1'b0, 1'b0, 2);
        idle(1);

        edge_bit(1'b1);
        check("noise_busy", 32'(o_busy), 32'd0);
        check("noise_pulses", {29'd0, o_valid, o_parity_err, o_frame_err}, 32'd0);
        idle(2);

        edge_bit(1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            edge_bit(1'($urandom));
        end
        idle(1);
        i_sclr = 1'b1;
        tick();
        i_sclr = 1'b0;
        model_data = 8'h00;
        check("sclr_data", 32'(o_data), 32'h00);
        check("sclr_pulses", {29'd0, o_valid, o_parity_err, o_frame_err}, 32'd0);
        check("sclr_busy", 32'(o_busy), 32'd0);
        idle(2);

        send_frame("good_f0", 8'hF0, 1'b1, 1'b1, 2);
        idle(1);
        send_frame("b2b_f0", 8'hF0, 1'b1, 1'b1, 1);
        idle(1);
        send_frame("b2b_1c", 8'h1C, 1'b0, 1'b1, 1);
        idle(2);

        // Stall mid-frame: start plus five data bits, then silence.
        edge_bit(1'b0);
        for (int i = 0; i < 5; i++) begin
            idle(2);
            edge_bit(1'($urandom));
        end
`ifdef PS2_RX_TIMEOUT_EN
        for (int k = 1; k < T; k++) begin
            idle(1);
            if (k < T - 1) check("wdog_wait", {30'd0, o_frame_err, o_busy}, 32'b01);
            else check("wdog_abort", {30'd0, o_frame_err, o_busy}, 32'b10);
        end
        check("wdog_valid", 32'(o_valid), 32'd0);
        check("wdog_data", 32'(o_data), 32'(model_data));
        idle(1);
        check("wdog_one_cycle", 32'(o_frame_err), 32'd0);
        send_frame("after_wdog", 8'h1C, 1'b0, 1'b1, 2);
`else
        idle(100);
        check("stall_busy", 32'(o_busy), 32'd1);
        check("stall_pulses", {29'd0, o_valid, o_parity_err, o_frame_err}, 32'd0);
        i_sclr = 1'b1;
        tick();
        i_sclr = 1'b0;
        model_data = 8'h00;
        check("stall_sclr_busy", 32'(o_busy), 32'd0);
        send_frame("after_stall", 8'h1C, 1'b0, 1'b1, 2);
`endif
        idle(1);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       par;
            logic       stop;
            d    = 8'($urandom);
            par  = ~(^d) ^ ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 2) == 0) begin
                edge_bit(1'b1);
                check("rand_noise", 32'(o_busy), 32'd0);
                idle(1);
            end
            send_frame("rand", d, par, stop, int'($urandom_range(1, 4)));
            idle(int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_frame_rx.md
Name: ps2_frame_rx

Overview:
- Framed PS/2 device-to-host receiver. Sits between the keyboard negedge detector and the scancode/hex display path.
- Consumes the one-cycle falling-edge strobe and the data line, and tracks the 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
- Emits a validated byte with a one-cycle strobe and separate parity and framing error strobes.
- Replaces the free-running shift capture so that downstream logic sees only whole, checked bytes.

Parameters:
- TIMEOUT_CYCLES, 10000, max clk cycles between PS/2 edges inside a frame before abort (200 us at 50 MHz). Used only with PS2_RX_TIMEOUT_EN.
- TIMEOUT_W, 14, width of the watchdog counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  input  1  system clock.
- i_sclr  input  1  synchronous active-high reset.
- i_en  input  1  one-cycle strobe per PS/2 clock falling edge (from the negedge detector).
- i_dat  input  1  PS/2 data, already synchronized; sampled only in cycles where i_en=1.
- o_data  output  8  last good received byte.
- o_valid  output  1  one-cycle pulse: o_data was just updated.
- o_parity_err  output  1  one-cycle pulse: frame had a good stop bit but bad parity.
- o_frame_err  output  1  one-cycle pulse: bad stop bit, or watchdog abort.
- o_busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- One clock; reset is synchronous and active-high (clk, i_sclr).
- Reset values: o_data=8'h00, o_valid=0, o_parity_err=0, o_frame_err=0, o_busy=0. FSM=IDLE, shift register=0, bit count=0.
- i_sclr has priority over everything. Asserting it mid-frame discards the partial frame with no error pulse.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only on cycles with i_en=1, except the watchdog abort.
- IDLE:
  - i_en with i_dat=0 (start bit): go to DATA, bit count=0.
  - i_en with i_dat=1: ignored, stay in IDLE, no pulse.
- DATA:
  - Each i_en: shreg <= {i_dat, shreg[7:1]} (LSB first), bit count +1.
  - On the 8th data bit (count 7 -> 8): go to PARITY.
- PARITY: on i_en, latch the parity bit and go to STOP.
- STOP: on i_en, always return to IDLE.
  - i_dat=1 and (^shreg ^ parity)=1 (odd parity OK): o_data <= shreg, o_valid pulses.
  - i_dat=1 and parity bad: o_parity_err pulses; o_data unchanged.
  - i_dat=0: o_frame_err pulses; parity is not reported; o_data unchanged.
- Output timing:
  - Pulses are registered: high exactly one cycle, in the cycle after the stop-bit i_en cycle.
  - At most one of o_valid / o_parity_err / o_frame_err is high in any cycle.
  - o_data changes only together with o_valid and holds between frames.
- o_busy=1 in DATA, PARITY and STOP. It drops in the cycle after the stop edge, the same cycle the result pulse appears.
- Back-to-back frames: a start bit on the first i_en after STOP is accepted normally. No dead time is required beyond the return to IDLE.
- i_en never asserts on consecutive cycles (guaranteed upstream); the block does not need to handle that case.

Optional Feature:
- Macro: PS2_RX_TIMEOUT_EN.
- Defined:
  - A TIMEOUT_W-bit watchdog clears on every i_en and on IDLE, and increments each cycle while not in IDLE.
  - If it reaches TIMEOUT_CYCLES-1 with no i_en, the FSM returns to IDLE and o_frame_err pulses once the next cycle. The partial byte is discarded.
  - An i_en in the same cycle as expiry wins: the edge is processed and the counter clears.
- Undefined: no counter logic. The FSM waits indefinitely for the next edge, and a stalled frame is recovered only by i_sclr.

Test Plan:
- Good frame 0x1C: start 0; data 0,0,1,1,1,0,0,0; parity 0; stop 1 -> one o_valid pulse, o_data=0x1C, no error pulses, o_busy low afterwards.
- Parity error: 0x1C frame with parity bit 1 -> o_parity_err single pulse, o_valid stays 0, o_data keeps its previous value.
- Framing error: 0x1C frame with stop bit 0 -> o_frame_err single pulse, o_parity_err=0, o_data unchanged.
- Idle noise, then reset mid-frame:
  - i_en with i_dat=1 in IDLE -> no pulse, o_busy stays 0.
  - Start + 4 data bits, then i_sclr for 1 cycle -> all outputs return to reset values.
  - Full 0xF0 frame (parity 1) -> o_valid, o_data=0xF0.
- Back-to-back frames: 0xF0 then 0x1C, with the second start edge 3 cycles after the first stop edge -> two o_valid pulses, o_data=0xF0 then 0x1C.
- Watchdog (PS2_RX_TIMEOUT_EN defined, TIMEOUT_CYCLES=16):
  - Start + 5 bits, then no edges -> o_frame_err pulse 16 cycles after the last edge, o_busy=0.
  - A following good 0x1C frame -> o_valid. Without the macro, the same stall keeps o_busy=1 indefinitely.
